// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: S-box, xtime, FSM encoding and key-size constants.
package aes_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, EXPAND} expState_t;

   localparam int NW_MAX = 60;

   function automatic int nkOf(input int keyBits);
      return keyBits / 32;
   endfunction

   function automatic int nrOf(input int keyBits);
      return nkOf(keyBits) + 6;
   endfunction

   function automatic int nwOf(input int keyBits);
      return 4 * (nrOf(keyBits) + 1);
   endfunction

   // GF(2^8) multiply by 2, reduction polynomial x^8+x^4+x^3+x+1
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-expander handshake and schedule bus; read port present when AES_KEY_EXP_RDPORT_EN is defined.
interface aes_key_expander_if;
   logic           start;
   logic [255:0]   keyIn;
   logic           busy;
   logic           done;
   logic           wValid;
   logic [1919:0]  w;
`ifdef AES_KEY_EXP_RDPORT_EN
   logic [3:0]     roundIdx;
   logic [127:0]   roundKey;

   modport master (output start, keyIn, roundIdx, input busy, done, wValid, w, roundKey);
   modport slave  (input start, keyIn, roundIdx, output busy, done, wValid, w, roundKey);
`else
   modport master (output start, keyIn, input busy, done, wValid, w);
   modport slave  (input start, keyIn, output busy, done, wValid, w);
`endif
endinterface

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box byte lookups.
module aes_sub_word
   import aes_pkg::*;
(
   input  logic [31:0] a,
   output logic [31:0] y
);
   for (genvar k = 0; k < 4; k++) begin : gByte
      assign y[8*k +: 8] = SBOX[a[8*k +: 8]];
   end
endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES key schedule, one word per cycle into a 60-word register array.
// Optional registered round-key read port under AES_KEY_EXP_RDPORT_EN.
module aes_key_expander
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 256
)(
   input  logic               clk,
   input  logic               rst_n,
   aes_key_expander_if.slave  kif
);
   localparam int NK = nkOf(KEY_BITS);
   localparam int NR = nrOf(KEY_BITS);
   localparam int NW = nwOf(KEY_BITS);
   localparam logic [5:0] NK_W      = 6'(NK);
   localparam logic [5:0] LAST_IDX  = 6'(NW - 1);
   localparam logic [2:0] KMOD_LAST = 3'(NK - 1);

   expState_t                 state;
   logic [255:0]              keyReg;
   logic [0:NW_MAX-1][31:0]   sched;
   logic [5:0]                idx;
   logic [2:0]                kmod;
   logic [7:0]                rcon;
   logic                      busyR, doneR, wValidR;

   logic [31:0] prevW, backW, rotW, subIn, subOut, temp, newW;

   assign prevW = sched[idx - 6'd1];
   assign backW = sched[idx - NK_W];
   assign rotW  = {prevW[23:0], prevW[31:24]};
   // Single SubWord shared by the rotated (kmod==0) and plain (AES-256 kmod==4) paths
   assign subIn = (kmod == 3'd0) ? rotW : prevW;

   aes_sub_word uSub (.a(subIn), .y(subOut));

   always_comb begin
      temp = prevW;
      if (kmod == 3'd0)
         temp = subOut ^ {rcon, 24'h0};
      else if (NK == 8 && kmod == 3'd4)
         temp = subOut;
   end

   assign newW = backW ^ temp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         keyReg  <= '0;
         sched   <= '0;
         idx     <= '0;
         kmod    <= '0;
         rcon    <= 8'h01;
         busyR   <= 1'b0;
         doneR   <= 1'b0;
         wValidR <= 1'b0;
      end else begin
         doneR <= 1'b0;
         case (state)
            IDLE: begin
               if (kif.start) begin
                  keyReg  <= kif.keyIn;
                  wValidR <= 1'b0;
                  busyR   <= 1'b1;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               for (int j = 0; j < 8; j++)
                  sched[j] <= (j < NK) ? keyReg[255-32*j -: 32] : 32'h0;
               for (int j = 8; j < NW_MAX; j++)
                  sched[j] <= 32'h0;
               idx   <= NK_W;
               kmod  <= '0;
               rcon  <= 8'h01;
               state <= EXPAND;
            end
            EXPAND: begin
               sched[idx] <= newW;
               idx        <= idx + 6'd1;
               kmod       <= (kmod == KMOD_LAST) ? 3'd0 : kmod + 3'd1;
               if (kmod == 3'd0)
                  rcon <= xtime(rcon);
               if (idx == LAST_IDX) begin
                  state   <= IDLE;
                  busyR   <= 1'b0;
                  doneR   <= 1'b1;
                  wValidR <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign kif.busy   = busyR;
   assign kif.done   = doneR;
   assign kif.wValid = wValidR;
   assign kif.w      = sched;

`ifdef AES_KEY_EXP_RDPORT_EN
   logic [5:0]   rdBase;
   logic [127:0] roundKeyR;

   assign rdBase = {kif.roundIdx, 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         roundKeyR <= '0;
      else if (kif.roundIdx > 4'(NR))
         roundKeyR <= '0;
      else
         roundKeyR <= {sched[rdBase], sched[rdBase + 6'd1],
                       sched[rdBase + 6'd2], sched[rdBase + 6'd3]};
   end

   assign kif.roundKey = roundKeyR;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench: 128/192/256-bit expanders checked against known schedule words via a scoreboard.
module tb_aes_key_expander;

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   typedef struct {
      int          d;
      int          idx;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   assertCnt = 0;
   int   failCnt   = 0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_key_expander_if if128 ();
   aes_key_expander_if if192 ();
   aes_key_expander_if if256 ();

   aes_key_expander #(.KEY_BITS(128)) dut128 (.clk(clk), .rst_n(rst_n), .kif(if128));
   aes_key_expander #(.KEY_BITS(192)) dut192 (.clk(clk), .rst_n(rst_n), .kif(if192));
   aes_key_expander #(.KEY_BITS(256)) dut256 (.clk(clk), .rst_n(rst_n), .kif(if256));

   function automatic logic [1919:0] busOf(input int d);
      return (d == 0) ? if128.w : (d == 1) ? if192.w : if256.w;
   endfunction

   function automatic logic [31:0] wordOf(input int d, input int i);
      logic [1919:0] v;
      v = busOf(d);
      return v[1919-32*i -: 32];
   endfunction

   function automatic logic doneOf(input int d);
      return (d == 0) ? if128.done : (d == 1) ? if192.done : if256.done;
   endfunction

   function automatic logic busyOf(input int d);
      return (d == 0) ? if128.busy : (d == 1) ? if192.busy : if256.busy;
   endfunction

   function automatic logic validOf(input int d);
      return (d == 0) ? if128.wValid : (d == 1) ? if192.wValid : if256.wValid;
   endfunction

   task automatic setIn(input int d, input logic s, input logic [255:0] key);
      case (d)
         0: begin if128.start = s; if128.keyIn = key; end
         1: begin if192.start = s; if192.keyIn = key; end
         default: begin if256.start = s; if256.keyIn = key; end
      endcase
   endtask

   task automatic pushExp(input int d, input int idx, input logic [31:0] val);
      exp_t e;
      e.d = d; e.idx = idx; e.val = val;
      sb.push_back(e);
   endtask

   task automatic startKey(input int d, input logic [255:0] key);
      @(negedge clk);
      setIn(d, 1'b1, key);
      @(posedge clk);
      #1;
      setIn(d, 1'b0, key);
   endtask

   task automatic waitDone(input int d, output int cyc);
      cyc = 0;
      while (cyc < 200) begin
         @(posedge clk);
         cyc++;
         #1;
         if (doneOf(d)) break;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         assertCnt++; if (busyOf(d) !== 1'b0) begin failCnt++; $display("FAIL reset_busy d%0d got %b want 0", d, busyOf(d)); end
         assertCnt++; if (doneOf(d) !== 1'b0) begin failCnt++; $display("FAIL reset_done d%0d got %b want 0", d, doneOf(d)); end
         assertCnt++; if (validOf(d) !== 1'b0) begin failCnt++; $display("FAIL reset_wValid d%0d got %b want 0", d, validOf(d)); end
         assertCnt++; if (busOf(d) !== '0) begin failCnt++; $display("FAIL reset_w d%0d nonzero, want 0", d); end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_aes128;
      int cyc;
      exp_t e;
      pushExp(0, 0, 32'h2b7e1516); pushExp(0, 3, 32'h09cf4f3c);
      pushExp(0, 4, 32'ha0fafe17); pushExp(0, 43, 32'hb6630ca6);
      for (int i = 44; i < 60; i++) pushExp(0, i, 32'h0);
      startKey(0, K128);
      assertCnt++; if (busyOf(0) !== 1'b1) begin failCnt++; $display("FAIL aes128_busy got %b want 1", busyOf(0)); end
      waitDone(0, cyc);
      assertCnt++; if (cyc != 41) begin failCnt++; $display("FAIL aes128_latency got %0d want 41", cyc); end
      assertCnt++; if (validOf(0) !== 1'b1) begin failCnt++; $display("FAIL aes128_wValid got %b want 1", validOf(0)); end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         assertCnt++;
         if (wordOf(e.d, e.idx) !== e.val) begin failCnt++; $display("FAIL aes128_w[%0d] got %h want %h", e.idx, wordOf(e.d, e.idx), e.val); end
      end
      @(posedge clk); #1;
      assertCnt++; if (doneOf(0) !== 1'b0) begin failCnt++; $display("FAIL aes128_done_pulse got %b want 0", doneOf(0)); end
      assertCnt++; if (validOf(0) !== 1'b1 || busyOf(0) !== 1'b0) begin failCnt++; $display("FAIL aes128_idle got wValid=%b busy=%b want 1/0", validOf(0), busyOf(0)); end
   endtask

   task automatic test_aes192;
      int cyc;
      exp_t e;
      pushExp(1, 0, 32'h8e73b0f7); pushExp(1, 5, 32'h522c6b7b);
      pushExp(1, 6, 32'hfe0c91f7); pushExp(1, 51, 32'h01002202);
      for (int i = 52; i < 60; i++) pushExp(1, i, 32'h0);
      startKey(1, K192);
      waitDone(1, cyc);
      assertCnt++; if (cyc != 47) begin failCnt++; $display("FAIL aes192_latency got %0d want 47", cyc); end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         assertCnt++;
         if (wordOf(e.d, e.idx) !== e.val) begin failCnt++; $display("FAIL aes192_w[%0d] got %h want %h", e.idx, wordOf(e.d, e.idx), e.val); end
      end
   endtask

   task automatic test_aes256;
      int cyc;
      exp_t e;
      pushExp(2, 0, 32'h603deb10); pushExp(2, 7, 32'h0914dff4);
      pushExp(2, 8, 32'h9ba35411); pushExp(2, 59, 32'h706c631e);
      startKey(2, K256);
      waitDone(2, cyc);
      assertCnt++; if (cyc != 53) begin failCnt++; $display("FAIL aes256_latency got %0d want 53", cyc); end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         assertCnt++;
         if (wordOf(e.d, e.idx) !== e.val) begin failCnt++; $display("FAIL aes256_w[%0d] got %h want %h", e.idx, wordOf(e.d, e.idx), e.val); end
      end
   endtask

   task automatic test_start_while_busy;
      int cyc;
      exp_t e;
      pushExp(2, 8, 32'h9ba35411); pushExp(2, 59, 32'h706c631e);
      startKey(2, K256);
      cyc = 0;
      while (cyc < 200) begin
         @(posedge clk);
         cyc++;
         #1;
         if (doneOf(2)) break;
         setIn(2, cyc == 10, K128);
      end
      setIn(2, 1'b0, K128);
      assertCnt++; if (cyc != 53) begin failCnt++; $display("FAIL busy_start_latency got %0d want 53", cyc); end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         assertCnt++;
         if (wordOf(e.d, e.idx) !== e.val) begin failCnt++; $display("FAIL busy_start_w[%0d] got %h want %h", e.idx, wordOf(e.d, e.idx), e.val); end
      end
      repeat (3) @(posedge clk); #1;
      assertCnt++; if (busyOf(2) !== 1'b0) begin failCnt++; $display("FAIL busy_start_no_rerun got busy=%b want 0", busyOf(2)); end
   endtask

   task automatic test_restart;
      int cyc;
      exp_t e;
      pushExp(0, 4, 32'ha0fafe17); pushExp(0, 43, 32'hb6630ca6);
      startKey(0, K128);
      assertCnt++; if (validOf(0) !== 1'b0) begin failCnt++; $display("FAIL restart_wValid_drop got %b want 0", validOf(0)); end
      waitDone(0, cyc);
      assertCnt++; if (cyc != 41) begin failCnt++; $display("FAIL restart_latency got %0d want 41", cyc); end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         assertCnt++;
         if (wordOf(e.d, e.idx) !== e.val) begin failCnt++; $display("FAIL restart_w[%0d] got %h want %h", e.idx, wordOf(e.d, e.idx), e.val); end
      end
   endtask

   task automatic test_reset_mid;
      int cyc;
      exp_t e;
      startKey(2, K256);
      repeat (19) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      assertCnt++; if (busyOf(2) !== 1'b0 || doneOf(2) !== 1'b0 || validOf(2) !== 1'b0) begin
         failCnt++; $display("FAIL midreset_ctrl got busy=%b done=%b wValid=%b want 0/0/0", busyOf(2), doneOf(2), validOf(2)); end
      assertCnt++; if (busOf(2) !== '0) begin failCnt++; $display("FAIL midreset_w nonzero, want 0"); end
      @(negedge clk);
      rst_n = 1'b1;
      pushExp(2, 8, 32'h9ba35411); pushExp(2, 59, 32'h706c631e);
      startKey(2, K256);
      waitDone(2, cyc);
      assertCnt++; if (cyc != 53) begin failCnt++; $display("FAIL midreset_latency got %0d want 53", cyc); end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         assertCnt++;
         if (wordOf(e.d, e.idx) !== e.val) begin failCnt++; $display("FAIL midreset_w[%0d] got %h want %h", e.idx, wordOf(e.d, e.idx), e.val); end
      end
   endtask

`ifdef AES_KEY_EXP_RDPORT_EN
   task automatic test_rdport;
      int cyc;
      logic [255:0] kSeq;
      kSeq = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      startKey(2, kSeq);
      waitDone(2, cyc);
      @(negedge clk); if256.roundIdx = 4'd0;
      @(posedge clk); #1;
      assertCnt++; if (if256.roundKey !== kSeq[255:128]) begin failCnt++; $display("FAIL rdport_r0 got %h want %h", if256.roundKey, kSeq[255:128]); end
      @(negedge clk); if256.roundIdx = 4'd14;
      @(posedge clk); #1;
      assertCnt++; if (if256.roundKey !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin failCnt++; $display("FAIL rdport_r14 got %h want 24fc79ccbf0979e9371ac23c6d68de36", if256.roundKey); end
      @(negedge clk); if256.roundIdx = 4'd15;
      @(posedge clk); #1;
      assertCnt++; if (if256.roundKey !== 128'h0) begin failCnt++; $display("FAIL rdport_r15 got %h want 0", if256.roundKey); end
   endtask
`endif

   initial begin
      for (int d = 0; d < 3; d++) setIn(d, 1'b0, '0);
`ifdef AES_KEY_EXP_RDPORT_EN
      if128.roundIdx = 4'd0; if192.roundIdx = 4'd0; if256.roundIdx = 4'd0;
`endif
      test_reset;
      test_aes128;
      test_aes192;
      test_aes256;
      test_start_while_busy;
      test_restart;
      test_reset_mid;
`ifdef AES_KEY_EXP_RDPORT_EN
      test_rdport;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule
